// File: rtl/responder_pkg.sv
// Shared types for the quiz responder answer-window timer.
package responder_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Out-of-range BCD digits from the time-select stage saturate at 9.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1 while enabled, pulses
// tick on the last count. Held at zero while disabled or cleared.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  // Wrap on the terminal count, otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    if (clr || !en)         count_d = '0;
    else if (count_q == LAST) count_d = '0;
    else                    count_d = count_q + CW'(1);
  end

  // Prescaler register with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RSTn) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Answer-window countdown for the quiz responder: two-digit BCD down-counter
// stepped by a one-second tick, with hold on buzz-in and timeout at 00.
// Optional low-time warning output enabled by the COUNTDOWN_WARN_EN macro.
//
// state   | meaning
// IDLE    | digits follow the sanitised preset, waiting for Start
// RUN     | counting down once per tick
// HOLD    | contestant buzzed in, digits frozen
// TIMEOUT | window expired, digits 00
module countdown_timer
  import responder_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int WARN_SECS = 5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  input  logic       Clear,
  input  logic       Answer_Valid,
  input  logic [3:0] TimerH_Set,
  input  logic [3:0] TimerL_Set,
  output logic [3:0] TimerH,
  output logic [3:0] TimerL,
  output logic       Running,
  output logic       Held,
  output logic       Time_Up,
  output logic       Warn
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("countdown_timer: TICK_DIV must be at least 2");
  end
  if (WARN_SECS < 1 || WARN_SECS > 9) begin : g_bad_warn_secs
    $error("countdown_timer: WARN_SECS must be 1..9");
  end

  state_t state_q, state_d;
  bcd_t   h_q, h_d, l_q, l_d;
  logic   running_q, held_q, time_up_q;
  logic   tick;

  bcd_t set_h, set_l;
  logic preset_zero;

  assign set_h       = bcd_clamp(TimerH_Set);
  assign set_l       = bcd_clamp(TimerL_Set);
  assign preset_zero = (set_h == 4'd0) && (set_l == 4'd0);

  // Answer_Valid also clears the count so a later re-open starts a full second.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (Start || Clear || Answer_Valid),
    .en   (state_q == RUN),
    .tick (tick)
  );

  // Next state and digits; priority Clear > Start > Answer_Valid > tick.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    if (Clear) begin
      state_d = IDLE;
      h_d     = set_h;
      l_d     = set_l;
    end else if (Start) begin
      state_d = preset_zero ? TIMEOUT : RUN;
      h_d     = set_h;
      l_d     = set_l;
    end else begin
      case (state_q)
        IDLE: begin
          h_d = set_h;
          l_d = set_l;
        end
        RUN: begin
          if (Answer_Valid) begin
            state_d = HOLD;
          end else if (tick) begin
            if (l_q == 4'd0) begin
              l_d = BCD_MAX;
              h_d = h_q - 4'd1;
            end else begin
              l_d = l_q - 4'd1;
            end
            if (h_q == 4'd0 && l_q == 4'd1) state_d = TIMEOUT;
          end
        end
        HOLD: ;
        TIMEOUT: begin
          h_d = 4'd0;
          l_d = 4'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, digits and status flags all registered together.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      state_q   <= IDLE;
      h_q       <= 4'd0;
      l_q       <= 4'd0;
      running_q <= 1'b0;
      held_q    <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      l_q       <= l_d;
      running_q <= (state_d == RUN);
      held_q    <= (state_d == HOLD);
      time_up_q <= (state_d == TIMEOUT);
    end
  end

  assign TimerH  = h_q;
  assign TimerL  = l_q;
  assign Running = running_q;
  assign Held    = held_q;
  assign Time_Up = time_up_q;

`ifdef COUNTDOWN_WARN_EN
  localparam bcd_t WARN_BCD = bcd_t'(WARN_SECS);
  logic warn_q, warn_d;

  // Low-time warning follows the next digits so it changes with them.
  always_comb begin
    warn_d = (state_d == RUN) && (h_d == 4'd0) && (l_d != 4'd0) && (l_d <= WARN_BCD);
  end

  // Warning register.
  always_ff @(posedge CLK) begin
    if (RSTn) warn_q <= 1'b0;
    else      warn_q <= warn_d;
  end

  assign Warn = warn_q;
`else
  assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, WARN_SECS=5.
module tb_countdown_timer;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b1;
  logic       Start = 1'b0;
  logic       Clear = 1'b0;
  logic       Answer_Valid = 1'b0;
  logic [3:0] TimerH_Set = 4'd0;
  logic [3:0] TimerL_Set = 4'd0;
  logic [3:0] TimerH, TimerL;
  logic       Running, Held, Time_Up, Warn;

  int n_checks = 0;
  int n_errors = 0;

  countdown_timer #(.TICK_DIV(4), .WARN_SECS(5)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Start        (Start),
    .Clear        (Clear),
    .Answer_Valid (Answer_Valid),
    .TimerH_Set   (TimerH_Set),
    .TimerL_Set   (TimerL_Set),
    .TimerH       (TimerH),
    .TimerL       (TimerL),
    .Running      (Running),
    .Held         (Held),
    .Time_Up      (Time_Up),
    .Warn         (Warn)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=stuck required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b1;
    TimerH_Set = 4'd1; TimerL_Set = 4'd7;
    step(2);
    n_checks++;
    if ({TimerH, TimerL, Running, Held, Time_Up, Warn} !== {8'h00, 4'b0000}) begin
      n_errors++;
      $display("FAIL reset_init: actual=%h%h flags=%b%b%b%b required=00 flags=0000",
               TimerH, TimerL, Running, Held, Time_Up, Warn);
    end
    RSTn = 1'b0;
    pulse_start();
    step(2);
    n_checks++;
    if ({TimerH, TimerL, Running} !== {8'h17, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_prerun: actual=%h%h run=%b required=17 run=1", TimerH, TimerL, Running);
    end
    RSTn = 1'b1;
    step(1);
    n_checks++;
    if ({TimerH, TimerL, Running, Held, Time_Up, Warn} !== {8'h00, 4'b0000}) begin
      n_errors++;
      $display("FAIL reset_midrun: actual=%h%h flags=%b%b%b%b required=00 flags=0000",
               TimerH, TimerL, Running, Held, Time_Up, Warn);
    end
    RSTn = 1'b0;
    step(1);
    n_checks++;
    if ({TimerH, TimerL, Running, Held, Time_Up} !== {8'h17, 3'b000}) begin
      n_errors++;
      $display("FAIL reset_idle_track: actual=%h%h flags=%b%b%b required=17 flags=000",
               TimerH, TimerL, Running, Held, Time_Up);
    end
  endtask

  task automatic test_countdown_12();
    TimerH_Set = 4'd1; TimerL_Set = 4'd2;
    pulse_start();
    n_checks++;
    if ({TimerH, TimerL, Running} !== {8'h12, 1'b1}) begin
      n_errors++;
      $display("FAIL cd12_start: actual=%h%h run=%b required=12 run=1", TimerH, TimerL, Running);
    end
    step(3);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h12) begin
      n_errors++;
      $display("FAIL cd12_plus3: actual=%h%h required=12", TimerH, TimerL);
    end
    step(1);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h11) begin
      n_errors++;
      $display("FAIL cd12_plus4: actual=%h%h required=11", TimerH, TimerL);
    end
    step(4);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h10) begin
      n_errors++;
      $display("FAIL cd12_plus8: actual=%h%h required=10", TimerH, TimerL);
    end
    step(4);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h09) begin
      n_errors++;
      $display("FAIL cd12_borrow: actual=%h%h required=09", TimerH, TimerL);
    end
    step(35);
    n_checks++;
    if ({TimerH, TimerL, Running, Time_Up} !== {8'h01, 2'b10}) begin
      n_errors++;
      $display("FAIL cd12_plus47: actual=%h%h run=%b up=%b required=01 run=1 up=0",
               TimerH, TimerL, Running, Time_Up);
    end
    step(1);
    n_checks++;
    if ({TimerH, TimerL, Running, Time_Up} !== {8'h00, 2'b01}) begin
      n_errors++;
      $display("FAIL cd12_timeout: actual=%h%h run=%b up=%b required=00 run=0 up=1",
               TimerH, TimerL, Running, Time_Up);
    end
  endtask

  task automatic test_hold();
    TimerH_Set = 4'd2; TimerL_Set = 4'd5;
    pulse_start();
    step(16);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h21) begin
      n_errors++;
      $display("FAIL hold_pre: actual=%h%h required=21", TimerH, TimerL);
    end
    Answer_Valid = 1'b1;
    step(1);
    Answer_Valid = 1'b0;
    n_checks++;
    if ({TimerH, TimerL, Running, Held} !== {8'h21, 2'b01}) begin
      n_errors++;
      $display("FAIL hold_enter: actual=%h%h run=%b held=%b required=21 run=0 held=1",
               TimerH, TimerL, Running, Held);
    end
    step(20);
    n_checks++;
    if ({TimerH, TimerL, Held} !== {8'h21, 1'b1}) begin
      n_errors++;
      $display("FAIL hold_frozen: actual=%h%h held=%b required=21 held=1", TimerH, TimerL, Held);
    end
    Start = 1'b1; Answer_Valid = 1'b1;
    step(1);
    Start = 1'b0; Answer_Valid = 1'b0;
    n_checks++;
    if ({TimerH, TimerL, Running, Held} !== {8'h25, 2'b10}) begin
      n_errors++;
      $display("FAIL hold_reopen: actual=%h%h run=%b held=%b required=25 run=1 held=0",
               TimerH, TimerL, Running, Held);
    end
    step(8);
    n_checks++;
    if ({TimerH, TimerL, Running} !== {8'h23, 1'b1}) begin
      n_errors++;
      $display("FAIL hold_rerun: actual=%h%h run=%b required=23 run=1", TimerH, TimerL, Running);
    end
    Start = 1'b1; Answer_Valid = 1'b1;
    step(1);
    Start = 1'b0; Answer_Valid = 1'b0;
    n_checks++;
    if ({TimerH, TimerL, Running, Held} !== {8'h25, 2'b10}) begin
      n_errors++;
      $display("FAIL run_start_answer: actual=%h%h run=%b held=%b required=25 run=1 held=0",
               TimerH, TimerL, Running, Held);
    end
    step(4);
    n_checks++;
    if ({TimerH, TimerL, Running} !== {8'h24, 1'b1}) begin
      n_errors++;
      $display("FAIL run_after_reload: actual=%h%h run=%b required=24 run=1", TimerH, TimerL, Running);
    end
  endtask

  task automatic test_answer_on_last_tick();
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
    TimerH_Set = 4'd0; TimerL_Set = 4'd2;
    pulse_start();
    step(7);
    Answer_Valid = 1'b1;
    step(1);
    Answer_Valid = 1'b0;
    n_checks++;
    if ({TimerH, TimerL, Held, Time_Up, Running} !== {8'h01, 3'b100}) begin
      n_errors++;
      $display("FAIL answer_last_tick: actual=%h%h held=%b up=%b run=%b required=01 held=1 up=0 run=0",
               TimerH, TimerL, Held, Time_Up, Running);
    end
  endtask

  task automatic test_presets();
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
    TimerH_Set = 4'd0; TimerL_Set = 4'd0;
    step(1);
    pulse_start();
    n_checks++;
    if ({TimerH, TimerL, Time_Up, Running} !== {8'h00, 2'b10}) begin
      n_errors++;
      $display("FAIL preset_zero: actual=%h%h up=%b run=%b required=00 up=1 run=0",
               TimerH, TimerL, Time_Up, Running);
    end
    Start = 1'b1; Clear = 1'b1;
    step(1);
    Start = 1'b0; Clear = 1'b0;
    n_checks++;
    if ({Time_Up, Running, Held} !== 3'b000) begin
      n_errors++;
      $display("FAIL start_clear_timeout: actual flags=%b%b%b required=000", Time_Up, Running, Held);
    end
    TimerH_Set = 4'hF; TimerL_Set = 4'hF;
    step(1);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h99) begin
      n_errors++;
      $display("FAIL clamp_idle: actual=%h%h required=99", TimerH, TimerL);
    end
    pulse_start();
    n_checks++;
    if ({TimerH, TimerL, Running} !== {8'h99, 1'b1}) begin
      n_errors++;
      $display("FAIL clamp_run: actual=%h%h run=%b required=99 run=1", TimerH, TimerL, Running);
    end
    step(4);
    n_checks++;
    if ({TimerH, TimerL} !== 8'h98) begin
      n_errors++;
      $display("FAIL clamp_dec: actual=%h%h required=98", TimerH, TimerL);
    end
  endtask

  task automatic test_warn();
    logic exp_warn;
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
    TimerH_Set = 4'd0; TimerL_Set = 4'd7;
    pulse_start();
    for (int v = 7; v >= 0; v--) begin
`ifdef COUNTDOWN_WARN_EN
      exp_warn = (v >= 1 && v <= 5);
`else
      exp_warn = 1'b0;
`endif
      n_checks++;
      if ({TimerL, Warn} !== {v[3:0], exp_warn}) begin
        n_errors++;
        $display("FAIL warn_v%0d: actual=%h warn=%b required=%0d warn=%b", v, TimerL, Warn, v, exp_warn);
      end
      if (v > 0) step(4);
    end
    n_checks++;
    if (Time_Up !== 1'b1) begin
      n_errors++;
      $display("FAIL warn_timeout: actual up=%b required up=1", Time_Up);
    end
  endtask

  initial begin
    test_reset();
    test_countdown_12();
    test_hold();
    test_answer_on_last_tick();
    test_presets();
    test_warn();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
